// File: rtl/kernel_sched.sv
// kernel_sched
// Round-robin scheduler that shares one iterative kernel between NREQ requesters.
// A requester is granted in IDLE and its operands are captured. The kernel is
// started with a one-cycle strobe. The scheduler then waits for the kernel's done
// level, or aborts after TMO run cycles. The result goes back to the owner as a
// one-cycle strobe.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset (release is synchronised)
//   req_valid / req_ready   per-requester launch request / grant strobe (grant is combinational)
//   req_i / req_acc         packed operands, slice r at [r*DW +: DW]
//   rsp_valid               one-cycle completion strobe on the owner's bit
//   rsp_data / rsp_err      result and timeout flag, valid with rsp_valid
//   k_r_enable              kernel start strobe
//   k_init_i / k_init_acc   kernel operands, held from launch to response
//   k_w_enable / k_result   kernel done level and result
//   busy                    high whenever the scheduler is not idle
module kernel_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int TMO  = 16384
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_i,
    input  logic [NREQ*DW-1:0]   req_acc,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 k_r_enable,
    output logic [DW-1:0]        k_init_i,
    output logic [DW-1:0]        k_init_acc,
    input  logic                 k_w_enable,
    input  logic [DW-1:0]        k_result,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r;
    logic [1:0]        rst_sync_r;
    logic              rst_core_n_s;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     gnt_idx_r;
    logic [CW-1:0]     cnt_r;
    logic              k_r_enable_r;
    logic [DW-1:0]     k_init_i_r;
    logic [DW-1:0]     k_init_acc_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [DW-1:0]     rsp_data_r;
    logic              rsp_err_r;

    logic              gnt_found_s;
    logic [IW-1:0]     gnt_idx_s;
    logic [IW-1:0]     cand_idx_s;
    logic              cand_hit_s;
    int                cand_v;

    // One-hot decode of a requester index
    function automatic logic [NREQ-1:0] onehot_f(input logic [IW-1:0] idx);
        onehot_f = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Reset synchroniser: assertion is immediate, release takes two clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_core_n_s = rst_sync_r[1];

    // Round-robin pick. The loop scans downwards from rr_ptr+NREQ-1 to rr_ptr,
    // so the nearest requester at or after rr_ptr is written last and wins.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_v      = 0;
        cand_idx_s  = '0;
        cand_hit_s  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_v      = (int'(rr_ptr_r) + k >= NREQ) ? (int'(rr_ptr_r) + k - NREQ)
                                                       : (int'(rr_ptr_r) + k);
            cand_idx_s  = IW'(cand_v);
            cand_hit_s  = req_valid[cand_idx_s];
            gnt_found_s = gnt_found_s | cand_hit_s;
            gnt_idx_s   = cand_hit_s ? cand_idx_s : gnt_idx_s;
        end
    end

    // Scheduler FSM; every kernel/response output is a register
    always_ff @(posedge clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            gnt_idx_r    <= '0;
            cnt_r        <= '0;
            k_r_enable_r <= 1'b0;
            k_init_i_r   <= '0;
            k_init_acc_r <= '0;
            rsp_valid_r  <= '0;
            rsp_data_r   <= '0;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_found_s) begin
                        gnt_idx_r    <= gnt_idx_s;
                        k_init_i_r   <= req_i[int'(gnt_idx_s)*DW +: DW];
                        k_init_acc_r <= req_acc[int'(gnt_idx_s)*DW +: DW];
                        k_r_enable_r <= 1'b1;
                        state_r      <= ST_LAUNCH;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    k_r_enable_r <= 1'b0;
                    cnt_r        <= '0;
                    state_r      <= ST_RUN;
                end
                ST_RUN: begin
                    // Completion wins over a timeout in the same cycle.
                    if (k_w_enable == 1'b1) begin
                        rsp_data_r  <= k_result;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= onehot_f(gnt_idx_r);
                        state_r     <= ST_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= onehot_f(gnt_idx_r);
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r       <= cnt_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    rr_ptr_r    <= (gnt_idx_r == LAST_IDX) ? '0 : (gnt_idx_r + IW'(1));
                    state_r     <= ST_IDLE;
                end
                default: begin
                    k_r_enable_r <= 1'b0;
                    rsp_valid_r  <= '0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant must be visible in the same IDLE cycle, so req_ready is decoded, not registered.
    assign req_ready  = (state_r == ST_IDLE && rst_core_n_s && gnt_found_s)
                        ? onehot_f(gnt_idx_s) : '0;
    assign busy       = (state_r != ST_IDLE);
    assign k_r_enable = k_r_enable_r;
    assign k_init_i   = k_init_i_r;
    assign k_init_acc = k_init_acc_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_kernel_sched.sv
// Directed testbench for kernel_sched. u0 uses the default TMO and u1 uses TMO=16.
// Each instance has a small kernel model that raises done a programmed number
// of run cycles after the start strobe.
module tb_kernel_sched;

    logic clk;
    logic rst_n;

    logic [3:0]   req_valid0, rdy0, rv0;
    logic [255:0] req_i0, req_acc0;
    logic [63:0]  rd0, k0_ii, k0_ia, k0_res;
    logic         re0, kre0, busy0;
    logic         k0_done = 1'b0;

    logic [3:0]   req_valid1, rdy1, rv1;
    logic [255:0] req_i1, req_acc1;
    logic [63:0]  rd1, k1_ii, k1_ia, k1_res;
    logic         re1, kre1, busy1;
    logic         k1_done = 1'b0;

    logic         stale0;
    logic         never1;
    int           delay0, delay1;
    logic [63:0]  kbase0;
    int           k0_cnt = 0;
    int           k1_cnt = 0;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           kre0_cnt = 0;
    int           gb, rb, kb, gb2;
    logic [3:0]   oh;

    int           g0_cyc[$], r0_cyc[$], g1_cyc[$], r1_cyc[$];
    logic [3:0]   g0_vec[$], r0_vec[$], g1_vec[$], r1_vec[$];
    logic [63:0]  r0_dat[$], r1_dat[$];
    logic         r0_err[$], r1_err[$];

    int           exp_ord[12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    logic [63:0]  exp_d[4]    = '{64'd100, 64'd201, 64'd302, 64'd403};

    kernel_sched #(.NREQ(4), .DW(64)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(rdy0),
        .req_i(req_i0), .req_acc(req_acc0),
        .rsp_valid(rv0), .rsp_data(rd0), .rsp_err(re0),
        .k_r_enable(kre0), .k_init_i(k0_ii), .k_init_acc(k0_ia),
        .k_w_enable(k0_done), .k_result(k0_res), .busy(busy0)
    );

    kernel_sched #(.NREQ(4), .DW(64), .TMO(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(rdy1),
        .req_i(req_i1), .req_acc(req_acc1),
        .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
        .k_r_enable(kre1), .k_init_i(k1_ii), .k_init_acc(k1_ia),
        .k_w_enable(k1_done), .k_result(k1_res), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kernel model u0: start clears done; stale0 forces a stale done level
    always @(posedge clk) begin
        if (kre0) begin
            k0_done <= 1'b0;
            k0_cnt  <= 1;
        end else if (stale0) begin
            k0_done <= 1'b1;
        end else if (k0_cnt != 0) begin
            if (k0_cnt == delay0) begin
                k0_done <= 1'b1;
                k0_res  <= kbase0 + k0_ii + k0_ia;
                k0_cnt  <= 0;
            end else begin
                k0_cnt  <= k0_cnt + 1;
            end
        end
    end

    // Kernel model u1: never1 suppresses done entirely
    always @(posedge clk) begin
        if (kre1) begin
            k1_done <= 1'b0;
            k1_cnt  <= 1;
        end else if (k1_cnt != 0) begin
            if (!never1 && k1_cnt == delay1) begin
                k1_done <= 1'b1;
                k1_res  <= k1_ii + k1_ia;
                k1_cnt  <= 0;
            end else begin
                k1_cnt  <= k1_cnt + 1;
            end
        end
    end

    // Event recorder: grants, responses and start strobes with their cycle number
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (|rdy0) begin g0_cyc.push_back(cyc); g0_vec.push_back(rdy0); end
        if (|rv0)  begin r0_cyc.push_back(cyc); r0_vec.push_back(rv0);
                         r0_dat.push_back(rd0); r0_err.push_back(re0); end
        if (|rdy1) begin g1_cyc.push_back(cyc); g1_vec.push_back(rdy1); end
        if (|rv1)  begin r1_cyc.push_back(cyc); r1_vec.push_back(rv1);
                         r1_dat.push_back(rd1); r1_err.push_back(re1); end
        if (kre0) kre0_cnt <= kre0_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid0 = 4'b0000; req_valid1 = 4'b0000;
        req_i0 = '0; req_acc0 = '0; req_i1 = '0; req_acc1 = '0;
        stale0 = 1'b1; never1 = 1'b0;
        delay0 = 20; delay1 = 4;
        kbase0 = 64'd332833500;
        req_valid0 = 4'b0001;

        // Reset state, with a request pending and a stale done level
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(rdy0), 64'd0);
        chk("rst_rsp_valid", 64'(rv0), 64'd0);
        chk("rst_rsp_err", 64'(re0), 64'd0);
        chk("rst_rsp_data", rd0, 64'd0);
        chk("rst_k_r_enable", 64'(kre0), 64'd0);
        chk("rst_k_init_i", k0_ii, 64'd0);
        chk("rst_k_init_acc", k0_ia, 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);

        gb = g0_cyc.size(); rb = r0_cyc.size(); kb = kre0_cnt;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_edge1_busy", 64'(busy0), 64'd0);

        // Single request, stale done masked, result after 20 run cycles
        for (int t = 0; t < 20 && g0_cyc.size() <= gb; t++) @(negedge clk);
        chk("t39_grant_seen", 64'(g0_cyc.size() > gb), 64'd1);
        req_valid0 = 4'b0000;
        stale0 = 1'b0;
        for (int t = 0; t < 100 && r0_cyc.size() <= rb; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("t39_rsp_count", 64'(r0_cyc.size() - rb), 64'd1);
        chk("t39_rsp_owner", 64'(r0_vec[rb]), 64'd1);
        chk("t39_rsp_data", r0_dat[rb], 64'd332833500);
        chk("t39_rsp_err", 64'(r0_err[rb]), 64'd0);
        chk("t39_latency", 64'(r0_cyc[rb] - g0_cyc[gb]), 64'd23);
        chk("t39_kre_pulses", 64'(kre0_cnt - kb), 64'd1);

        // Four requesters continuously valid, 12 back-to-back jobs
        kbase0 = 64'd0; delay0 = 3;
        for (int r = 0; r < 4; r++) begin
            req_i0[r*64 +: 64]   = 64'(100 * (r + 1));
            req_acc0[r*64 +: 64] = 64'(r);
        end
        gb = g0_cyc.size(); rb = r0_cyc.size();
        req_valid0 = 4'b1111;
        for (int t = 0; t < 200 && g0_cyc.size() < gb + 12; t++) @(negedge clk);
        req_valid0 = 4'b0000;
        for (int t = 0; t < 50 && r0_cyc.size() < rb + 12; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("t40_grant_count", 64'(g0_cyc.size() - gb), 64'd12);
        chk("t40_rsp_count", 64'(r0_cyc.size() - rb), 64'd12);
        for (int j = 0; j < 12; j++) begin
            oh = 4'b0001 << exp_ord[j];
            chk($sformatf("t40_grant_%0d", j), 64'(g0_vec[gb+j]), 64'(oh));
            chk($sformatf("t40_owner_%0d", j), 64'(r0_vec[rb+j]), 64'(oh));
            chk($sformatf("t40_data_%0d", j), r0_dat[rb+j], exp_d[exp_ord[j]]);
        end
        for (int j = 0; j < 11; j++) begin
            chk($sformatf("t40_period_%0d", j), 64'(g0_cyc[gb+j+1] - g0_cyc[gb+j]), 64'd7);
        end

        // Reset mid-run while requester 2 owns the kernel
        delay0 = 50;
        gb = g0_cyc.size(); rb = r0_cyc.size();
        req_valid0 = 4'b0100;
        for (int t = 0; t < 20 && g0_cyc.size() <= gb; t++) @(negedge clk);
        chk("t43_grant2", 64'(g0_vec[gb]), 64'd4);
        req_valid0 = 4'b0000;
        repeat (5) @(negedge clk);
        chk("t43_busy_in_run", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        req_valid0 = 4'b1010;
        #1;
        chk("t43_rst_req_ready", 64'(rdy0), 64'd0);
        chk("t43_rst_busy", 64'(busy0), 64'd0);
        chk("t43_rst_k_init_i", k0_ii, 64'd0);
        chk("t43_rst_k_init_acc", k0_ia, 64'd0);
        chk("t43_rst_k_r_enable", 64'(kre0), 64'd0);
        chk("t43_rst_rsp_data", rd0, 64'd0);
        chk("t43_rst_rsp_valid", 64'(rv0), 64'd0);
        repeat (2) @(negedge clk);
        delay0 = 3;
        gb2 = g0_cyc.size();
        rst_n = 1'b1;
        for (int t = 0; t < 20 && g0_cyc.size() <= gb2; t++) @(negedge clk);
        chk("t43_first_grant", 64'(g0_vec[gb2]), 64'd2);
        req_valid0 = 4'b1000;
        for (int t = 0; t < 30 && g0_cyc.size() <= gb2 + 1; t++) @(negedge clk);
        chk("t43_second_grant", 64'(g0_vec[gb2+1]), 64'd8);
        req_valid0 = 4'b0000;
        for (int t = 0; t < 40 && r0_cyc.size() < rb + 2; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("t43_rsp_count", 64'(r0_cyc.size() - rb), 64'd2);
        chk("t43_rsp0_owner", 64'(r0_vec[rb]), 64'd2);
        chk("t43_rsp0_data", r0_dat[rb], 64'd201);
        chk("t43_rsp1_owner", 64'(r0_vec[rb+1]), 64'd8);
        chk("t43_rsp1_data", r0_dat[rb+1], 64'd403);

        // Timeout on u1 (TMO=16), kernel never finishes
        never1 = 1'b1;
        req_i1[0 +: 64] = 64'd5; req_acc1[0 +: 64] = 64'd6;
        gb = g1_cyc.size(); rb = r1_cyc.size();
        req_valid1 = 4'b0001;
        for (int t = 0; t < 20 && g1_cyc.size() <= gb; t++) @(negedge clk);
        req_valid1 = 4'b0000;
        for (int t = 0; t < 60 && r1_cyc.size() <= rb; t++) @(negedge clk);
        chk("t41_rsp_seen", 64'(r1_cyc.size() - rb), 64'd1);
        chk("t41_owner", 64'(r1_vec[rb]), 64'd1);
        chk("t41_err", 64'(r1_err[rb]), 64'd1);
        chk("t41_data", r1_dat[rb], 64'd0);
        chk("t41_latency", 64'(r1_cyc[rb] - g1_cyc[gb]), 64'd18);

        // Next request after a timeout is served normally
        never1 = 1'b0; delay1 = 4;
        req_i1[64 +: 64] = 64'd7; req_acc1[64 +: 64] = 64'd8;
        gb = g1_cyc.size(); rb = r1_cyc.size();
        req_valid1 = 4'b0010;
        for (int t = 0; t < 20 && g1_cyc.size() <= gb; t++) @(negedge clk);
        req_valid1 = 4'b0000;
        for (int t = 0; t < 40 && r1_cyc.size() <= rb; t++) @(negedge clk);
        chk("t41b_owner", 64'(r1_vec[rb]), 64'd2);
        chk("t41b_data", r1_dat[rb], 64'd15);
        chk("t41b_err", 64'(r1_err[rb]), 64'd0);
        chk("t41b_latency", 64'(r1_cyc[rb] - g1_cyc[gb]), 64'd7);

        // Done and timeout in the same run cycle: completion wins
        delay1 = 15;
        req_i1[128 +: 64] = 64'h10; req_acc1[128 +: 64] = 64'h20;
        gb = g1_cyc.size(); rb = r1_cyc.size();
        req_valid1 = 4'b0100;
        for (int t = 0; t < 20 && g1_cyc.size() <= gb; t++) @(negedge clk);
        req_valid1 = 4'b0000;
        for (int t = 0; t < 60 && r1_cyc.size() <= rb; t++) @(negedge clk);
        chk("t44_owner", 64'(r1_vec[rb]), 64'd4);
        chk("t44_err", 64'(r1_err[rb]), 64'd0);
        chk("t44_data", r1_dat[rb], 64'h30);
        chk("t44_latency", 64'(r1_cyc[rb] - g1_cyc[gb]), 64'd18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_sched.md
KERNEL_SCHED -- requirements
Module: kernel_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one kernel instance, range 2..8.
REQ-002 SHALL have parameter DW, default 64: operand and result width.
REQ-003 SHALL have parameter TMO, default 16384: maximum run cycles before abort, at least 16.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester launch request.
REQ-007 SHALL have port req_ready  out  NREQ  per-requester grant/accept strobe.
REQ-008 SHALL have port req_i  in  NREQ*DW  init_i operand; slice r is bits [r*DW +: DW].
REQ-009 SHALL have port req_acc  in  NREQ*DW  init_acc operand; sliced as req_i.
REQ-010 SHALL have port rsp_valid  out  NREQ  one-cycle completion strobe to the owning requester.
REQ-011 SHALL have port rsp_data  out  DW  result, valid while any rsp_valid bit is high.
REQ-012 SHALL have port rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-013 SHALL have port k_r_enable  out  1  kernel start/load strobe.
REQ-014 SHALL have port k_init_i  out  DW  kernel init_i.
REQ-015 SHALL have port k_init_acc  out  DW  kernel init_acc.
REQ-016 SHALL have port k_w_enable  in  1  kernel done level; stays high until the next start.
REQ-017 SHALL have port k_result  in  DW  kernel result, valid while k_w_enable is high.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> LAUNCH -> RUN -> RESP -> IDLE, each arc taken on one clock edge except RUN.
REQ-020 In IDLE, if any req_valid bit is set, SHALL select the first set index at or after rr_ptr (modulo NREQ) and assert req_ready for that index only, combinationally in the same cycle.
REQ-021 SHALL latch the grant index and both operand slices on the grant edge, then enter LAUNCH; the requester may drop req_valid after that edge.
REQ-022 SHALL drive req_ready to zero in every state other than IDLE; a new request received while busy waits with no loss.
REQ-023 In LAUNCH, SHALL drive k_r_enable=1 for exactly one cycle, with k_init_i and k_init_acc holding the latched operands.
REQ-024 SHALL keep k_init_* held stable from LAUNCH through RESP.
REQ-025 SHALL drive k_r_enable=0 in all other states.
REQ-026 In RUN, SHALL clear the cycle counter on entry and increment it by 1 every RUN cycle.
REQ-027 SHALL ignore k_w_enable in every state except RUN; this masks a stale done level or X from power-up.
REQ-028 In RUN, when k_w_enable=1, SHALL latch k_result into rsp_data, clear the error flag, and enter RESP.
REQ-029 In RUN, when the counter reaches TMO-1 and k_w_enable=0, SHALL set rsp_data=0 and rsp_err=1, then enter RESP.
REQ-030 If k_w_enable and timeout occur in the same cycle, SHALL give completion priority.
REQ-031 In RESP, SHALL assert rsp_valid[granted index] for one cycle, with rsp_data and rsp_err held.
REQ-032 On leaving RESP, SHALL set rr_ptr = (granted index + 1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-033 Latency: grant cycle G, k_r_enable at G+1, RUN from G+2; rsp_valid appears 1 cycle after the RUN cycle that sees done; minimum 4 cycles from grant to response.
REQ-034 SHALL allow a grant in the IDLE cycle immediately after RESP, giving back-to-back service with no bubble.
REQ-035 Counter width SHALL be clog2(TMO) bits and SHALL never wrap within a run.

Reset
REQ-036 While rst_n=0, SHALL immediately force: state=IDLE, rr_ptr=0, counter=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, k_r_enable=0, k_init_i=0, k_init_acc=0, busy=0.
REQ-037 A reset during LAUNCH, RUN or RESP SHALL abandon the job silently, with no rsp_valid, and the first post-reset grant SHALL go to the lowest requesting index.
REQ-038 Deassertion of rst_n SHALL be synchronised to clk before FSM use, so state leaves IDLE no earlier than the second edge after release.

Verification
REQ-039 Single request: req_valid[0]=1, i=0, acc=0, kernel model answers done with result 332833500 after 20 cycles -> one rsp_valid[0] pulse, rsp_data=332833500, rsp_err=0, k_r_enable pulsed exactly once.
REQ-040 All four requesters continuously valid, 12 jobs -> grant order 0,1,2,3,0,1,2,3,... and each rsp_valid lands only on the owner's bit.
REQ-041 Kernel model never asserts done, TMO=16 -> rsp_err=1 and rsp_data=0 exactly 16 RUN cycles after entry; the next request is served normally.
REQ-042 k_w_enable held at 1 before the first launch (stale) -> no early completion; response only after the model drops and re-raises done.
REQ-043 rst_n pulsed low mid-RUN with requester 2 owning the kernel -> no rsp_valid; all outputs zero during reset; after release, requests from 1 and 3 are granted to 1 first.
REQ-044 Done and timeout in the same cycle (TMO=16, done on RUN cycle 15) -> rsp_err=0, rsp_data=k_result.
